// File: rtl/fwd_select_gen.sv
// Forwarding-select generator: shadows in-flight destination registers
// and produces registered EX operand-mux selects plus a load-use stall.
module fwd_select_gen #(
    parameter int REG_AW       = 5,
    parameter bit X0_HARDWIRED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    input  logic              hold,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall
);

    typedef enum logic [1:0] {
        SEL_RF  = 2'b00,
        SEL_WB  = 2'b01,
        SEL_MEM = 2'b10,
        SEL_RET = 2'b11
    } sel_e;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic              ld;
    } ex_t;

    // Past EX only "can it forward" matters, so v/rw/x0 fold into one bit.
    typedef struct packed {
        logic              live;
        logic [REG_AW-1:0] rd;
    } prod_t;

    ex_t   ex_q, ex_d;
    prod_t mem_q, mem_d;
    prod_t wb_q, wb_d;
    sel_e  a_q, a_d;
    sel_e  b_q, b_d;

    logic ex_live;
    logic ex_a, ex_b;
    logic mem_a, mem_b;
    logic wb_a, wb_b;
    logic ld_hazard;

    function automatic sel_e pick(
        input logic en,
        input logic e,
        input logic m,
        input logic w
    );
        sel_e s;
        s = SEL_RF;
        if (en) begin
            if (e)      s = SEL_MEM;
            else if (m) s = SEL_WB;
            else if (w) s = SEL_RET;
        end
        return s;
    endfunction

    assign ex_live = ex_q.v & ex_q.rw &
                     ((ex_q.rd != '0) | ~X0_HARDWIRED);

    assign ex_a  = ex_live & (ex_q.rd == id_rs1);
    assign ex_b  = ex_live & (ex_q.rd == id_rs2);
    assign mem_a = mem_q.live & (mem_q.rd == id_rs1);
    assign mem_b = mem_q.live & (mem_q.rd == id_rs2);
    assign wb_a  = wb_q.live & (wb_q.rd == id_rs1);
    assign wb_b  = wb_q.live & (wb_q.rd == id_rs2);

    assign ld_hazard = id_valid & ex_q.ld &
                       ((id_use_rs1 & ex_a) | (id_use_rs2 & ex_b));

    assign stall = ld_hazard & ~flush;

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        a_d   = a_q;
        b_d   = b_q;
        if (!hold) begin
            mem_d.live = ex_live;
            mem_d.rd   = ex_q.rd;
            wb_d       = mem_q;
            if (flush || ld_hazard) begin
                ex_d = '0;
                a_d  = SEL_RF;
                b_d  = SEL_RF;
            end else begin
                ex_d.v  = id_valid;
                ex_d.rd = id_rd;
                ex_d.rw = id_regwrite;
                ex_d.ld = id_memread;
                a_d = pick(id_valid & id_use_rs1, ex_a, mem_a, wb_a);
                b_d = pick(id_valid & id_use_rs2, ex_b, mem_b, wb_b);
            end
        end
    end

    // WB->RET is the oldest forward; nothing beyond WB needs tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            a_q   <= SEL_RF;
            b_q   <= SEL_RF;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    assign fwd_a_sel = a_q;
    assign fwd_b_sel = b_q;

endmodule

// File: tb/tb_fwd_select_gen.sv
// Bench for fwd_select_gen: age-based producer model plus directed
// instruction sequences with hand-computed select/stall values.
module tb_fwd_select_gen;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2;
    logic       id_regwrite, id_memread;
    logic       flush, hold;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall;

    int errs   = 0;
    int checks = 0;

    fwd_select_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rd      (id_rd),
        .id_regwrite(id_regwrite),
        .id_memread (id_memread),
        .flush      (flush),
        .hold       (hold),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each issued instruction remembers the pipeline time it
    // entered EX; its age (0=EX,1=MEM,2=WB,3=RET) is the time elapsed.
    typedef struct {
        logic [4:0] rd;
        bit         rw;
        bit         ld;
        int         t;
    } ent_t;

    ent_t       q[$];
    int         ptime;
    logic [1:0] m_a, m_b;

    function automatic bit has(int age, logic [4:0] rs, bit need_ld);
        foreach (q[i])
            if (ptime - q[i].t == age && q[i].rw && q[i].rd != 0 &&
                q[i].rd == rs && (!need_ld || q[i].ld))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        return !flush && id_valid &&
               ((id_use_rs1 && has(0, id_rs1, 1'b1)) ||
                (id_use_rs2 && has(0, id_rs2, 1'b1)));
    endfunction

    function automatic logic [1:0] m_sel(bit use_x, logic [4:0] rs);
        if (!(id_valid && use_x)) return 2'b00;
        if (has(0, rs, 1'b0)) return 2'b10;
        if (has(1, rs, 1'b0)) return 2'b01;
        if (has(2, rs, 1'b0)) return 2'b11;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            ptime = 0;
            m_a   = 2'b00;
            m_b   = 2'b00;
        end else if (!hold) begin
            if (flush || m_stall()) begin
                m_a = 2'b00;
                m_b = 2'b00;
            end else begin
                m_a = m_sel(id_use_rs1, id_rs1);
                m_b = m_sel(id_use_rs2, id_rs2);
                if (id_valid)
                    q.push_back('{id_rd, id_regwrite, id_memread, ptime + 1});
            end
            ptime++;
            while (q.size() > 0 && ptime - q[0].t > 3) void'(q.pop_front());
        end
    end

    task automatic chk(string nm, logic [1:0] got, logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_stall", {1'b0, stall}, {1'b0, m_stall()});
        chk("model_a", fwd_a_sel, m_a);
        chk("model_b", fwd_b_sel, m_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(bit v, logic [4:0] rd, logic [4:0] rs1,
                          logic [4:0] rs2, bit u1, bit u2, bit rw, bit ld);
        id_valid    = v;
        id_rd       = rd;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_regwrite = rw;
        id_memread  = ld;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();
    endtask

    logic [1:0] dist_exp [3];

    initial begin
        dist_exp[0] = 2'b01;
        dist_exp[1] = 2'b11;
        dist_exp[2] = 2'b00;
        rst_n = 1'b0;
        flush = 1'b0;
        hold  = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        chk("rst_a", fwd_a_sel, 2'b00);
        chk("rst_b", fwd_b_sel, 2'b00);
        chk("rst_stall", {1'b0, stall}, 2'b00);
        rst_n = 1'b1;
        tick();

        // back-to-back ALU dependency
        set_id(1, 5, 1, 2, 1, 1, 1, 0);
        tick();
        set_id(1, 6, 5, 1, 1, 1, 1, 0);
        tick();
        chk("t1_a", fwd_a_sel, 2'b10);
        chk("t1_b", fwd_b_sel, 2'b00);
        drain();

        // producer of x9 at distance 2/3/4
        for (int d = 2; d <= 4; d++) begin
            set_id(1, 9, 1, 2, 1, 1, 1, 0);
            tick();
            set_id(0, 0, 0, 0, 0, 0, 0, 0);
            repeat (d - 1) tick();
            set_id(1, 20, 0, 9, 0, 1, 1, 0);
            tick();
            chk("t2_b", fwd_b_sel, dist_exp[d-2]);
            chk("t2_a", fwd_a_sel, 2'b00);
            drain();
        end

        // load-use
        set_id(1, 7, 1, 0, 1, 0, 1, 1);
        tick();
        set_id(1, 8, 7, 7, 1, 1, 1, 0);
        #1;
        chk("t3_stall", {1'b0, stall}, 2'b01);
        tick();
        chk("t3_bub_a", fwd_a_sel, 2'b00);
        chk("t3_bub_b", fwd_b_sel, 2'b00);
        chk("t3_stall2", {1'b0, stall}, 2'b00);
        tick();
        chk("t3_a", fwd_a_sel, 2'b01);
        chk("t3_b", fwd_b_sel, 2'b01);
        drain();

        // x0 never forwards or stalls
        set_id(1, 0, 0, 0, 0, 0, 1, 0);
        tick();
        set_id(1, 1, 0, 0, 1, 1, 1, 0);
        tick();
        chk("t4_a", fwd_a_sel, 2'b00);
        chk("t4_b", fwd_b_sel, 2'b00);
        set_id(1, 0, 1, 0, 1, 0, 1, 1);
        tick();
        set_id(1, 2, 0, 0, 1, 1, 1, 0);
        #1;
        chk("t4_stall", {1'b0, stall}, 2'b00);
        tick();
        chk("t4_a2", fwd_a_sel, 2'b00);
        chk("t4_b2", fwd_b_sel, 2'b00);
        drain();

        // youngest producer wins
        set_id(1, 3, 1, 0, 1, 0, 1, 0);
        tick();
        set_id(1, 3, 2, 0, 1, 0, 1, 0);
        tick();
        set_id(1, 12, 3, 0, 1, 0, 1, 0);
        tick();
        chk("t5_young", fwd_a_sel, 2'b10);
        drain();

        // flush beats load-use
        set_id(1, 10, 0, 0, 0, 0, 1, 1);
        tick();
        set_id(1, 13, 10, 10, 1, 1, 1, 0);
        flush = 1'b1;
        #1;
        chk("t5_fl_stall", {1'b0, stall}, 2'b00);
        tick();
        flush = 1'b0;
        chk("t5_fl_a", fwd_a_sel, 2'b00);
        chk("t5_fl_b", fwd_b_sel, 2'b00);
        drain();

        // hold freezes everything
        set_id(1, 11, 0, 0, 0, 0, 1, 0);
        tick();
        set_id(1, 15, 11, 0, 1, 0, 1, 0);
        tick();
        chk("t5_pre_a", fwd_a_sel, 2'b10);
        hold = 1'b1;
        set_id(1, 16, 15, 11, 1, 1, 1, 0);
        repeat (3) begin
            tick();
            chk("t5_hold_a", fwd_a_sel, 2'b10);
            chk("t5_hold_b", fwd_b_sel, 2'b00);
        end
        hold = 1'b0;
        tick();
        chk("t5_rel_a", fwd_a_sel, 2'b10);
        chk("t5_rel_b", fwd_b_sel, 2'b01);
        drain();

        // reset mid-stream
        set_id(1, 4, 0, 0, 0, 0, 1, 0);
        tick();
        set_id(1, 4, 4, 0, 1, 0, 1, 0);
        tick();
        chk("t6_pre_a", fwd_a_sel, 2'b10);
        set_id(1, 17, 4, 4, 1, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_a", fwd_a_sel, 2'b00);
        chk("t6_rst_b", fwd_b_sel, 2'b00);
        chk("t6_rst_stall", {1'b0, stall}, 2'b00);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_post_a", fwd_a_sel, 2'b00);
        chk("t6_post_b", fwd_b_sel, 2'b00);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
